// File: rtl/fwd_scoreboard.sv
// ============================================================================
// fwd_scoreboard
// ----------------------------------------------------------------------------
// Forwarding / interlock unit placed beside the decode stage. It tracks the
// register writers that are in flight in the stages after decode (entry k is
// the instruction k+1 stages past D). For every source operand it finds the
// youngest in-flight writer of that register. If that writer's result is
// already on its stage bus, the unit forwards the value. If the result is not
// ready yet, the unit raises a decode stall.
//
// Optional feature (macro FWD_STATS_EN):
//   Adds two saturating 32-bit statistics counters:
//     stat_stall_cyc  counts the cycles in which stall is high.
//     stat_fwd_cnt    counts forwarded operands that are used, summed over
//                     the cycles in which the instruction moves on.
//   When the macro is undefined, these ports and counters do not exist.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset; clears the tracker
//   advance      the pipeline moves this cycle
//   flush        kills all tracked writers (takes priority over advance)
//   issue_valid  the decode instruction writes a register
//   issue_dst    destination register of the decode instruction
//   issue_rdy    first stage index whose bus carries the result
//   src_used     per operand: the operand is really read
//   src_addr     per operand: register address, REG_AW bits each
//   src_rf       per operand: register-file read data, DATA_W bits each
//   stage_data   per stage: result bus, DATA_W bits each
//   src_data     per operand: resolved value
//   fwd_hit      per operand: the value was taken from a stage bus
//   stall        decode must hold
// ============================================================================
module fwd_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 3,
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    localparam int RDY_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         advance,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [REG_AW-1:0]            issue_dst,
    input  logic [RDY_W-1:0]             issue_rdy,
    input  logic [NUM_SRC-1:0]           src_used,
    input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]    src_rf,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic [NUM_SRC-1:0]           fwd_hit,
`ifdef FWD_STATS_EN
    output logic [31:0]                  stat_stall_cyc,
    output logic [31:0]                  stat_fwd_cnt,
`endif
    output logic                         stall
);

    // ------------------------------------------------------------------
    // Tracker: one entry per stage after decode.
    // ------------------------------------------------------------------
    logic              valid_reg [NUM_STAGES];
    logic [REG_AW-1:0] dst_reg   [NUM_STAGES];
    logic [RDY_W-1:0]  rdy_reg   [NUM_STAGES];

    logic [NUM_SRC-1:0] stall_vec;
    logic               issue_accept;

    // A stalled decode instruction is replaced by a bubble. Writes to r0 are
    // never tracked, so a read of r0 can never be forwarded or stalled.
    assign issue_accept = issue_valid && !stall && (issue_dst != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg[gi] <= 1'b0;
                    dst_reg[gi]   <= '0;
                    rdy_reg[gi]   <= '0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (advance) begin
                    if (gi == 0) begin
                        valid_reg[gi] <= issue_accept;
                        dst_reg[gi]   <= issue_dst;
                        rdy_reg[gi]   <= issue_rdy;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        dst_reg[gi]   <= dst_reg[gi-1];
                        rdy_reg[gi]   <= rdy_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Resolve: one priority chain per operand. The chain runs from the
    // oldest entry to the youngest, so the youngest match (lowest k)
    // overrides older ones at chain position 0.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] addr;
            logic [NUM_STAGES:0] found_c;
            logic [NUM_STAGES:0] ready_c;
            logic [DATA_W-1:0]   data_c [NUM_STAGES+1];
            logic                hit;

            assign addr = src_addr[gi*REG_AW +: REG_AW];

            assign found_c[NUM_STAGES] = 1'b0;
            assign ready_c[NUM_STAGES] = 1'b0;
            assign data_c[NUM_STAGES]  = '0;

            genvar gk;
            for (gk = 0; gk < NUM_STAGES; gk++) begin : g_chain
                logic match;
                logic ready;
                assign match = valid_reg[gk] && (dst_reg[gk] == addr) && (addr != '0);
                // Stage gk carries the result once gk >= rdy. An entry with
                // rdy = NUM_STAGES is never ready.
                assign ready = (rdy_reg[gk] <= RDY_W'(gk));
                assign found_c[gk] = match | found_c[gk+1];
                assign ready_c[gk] = match ? ready : ready_c[gk+1];
                assign data_c[gk]  = match ? stage_data[gk*DATA_W +: DATA_W] : data_c[gk+1];
            end

            assign hit           = found_c[0] & ready_c[0];
            assign fwd_hit[gi]   = hit;
            assign src_data[gi*DATA_W +: DATA_W] = hit ? data_c[0] : src_rf[gi*DATA_W +: DATA_W];
            assign stall_vec[gi] = found_c[0] & ~ready_c[0] & src_used[gi];
        end
    endgenerate

    assign stall = |stall_vec;

`ifdef FWD_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters. A flush does not clear them.
    // ------------------------------------------------------------------
    logic [31:0] stall_cyc_reg;
    logic [31:0] fwd_cnt_reg;
    logic [32:0] fwd_sum;

    assign fwd_sum = {1'b0, fwd_cnt_reg} + 33'($countones(fwd_hit & src_used));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cyc_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            if (stall && (stall_cyc_reg != 32'hFFFF_FFFF))
                stall_cyc_reg <= stall_cyc_reg + 32'd1;
            if (advance && !stall)
                fwd_cnt_reg <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

    assign stat_stall_cyc = stall_cyc_reg;
    assign stat_fwd_cnt   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// ============================================================================
// tb_fwd_scoreboard
// Scoreboard testbench for fwd_scoreboard (default build).
//
// The stimulus process drives one instruction per cycle. For each cycle it
// computes the expected outputs from a reference model and pushes them into
// a queue. A separate monitor process pops one expectation at every falling
// clock edge and compares it with the design's outputs.
//
// The reference model keeps a list of in-flight writers. Each writer holds
// its destination register, its ready stage and its age.
// ============================================================================
module tb_fwd_scoreboard;
    localparam int NS = 3;
    localparam int NSRC = 3;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RW = $clog2(NS + 1);

    bit clk = 1'b0;
    logic reset_n;
    logic advance, flush, issue_valid;
    logic [AW-1:0]      issue_dst;
    logic [RW-1:0]      issue_rdy;
    logic [NSRC-1:0]    src_used;
    logic [NSRC*AW-1:0] src_addr;
    logic [NSRC*DW-1:0] src_rf;
    logic [NS*DW-1:0]   stage_data;
    logic [NSRC*DW-1:0] src_data;
    logic [NSRC-1:0]    fwd_hit;
    logic               stall;

    fwd_scoreboard #(.NUM_STAGES(NS), .NUM_SRC(NSRC), .DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_rdy(issue_rdy),
        .src_used(src_used), .src_addr(src_addr), .src_rf(src_rf),
        .stage_data(stage_data), .src_data(src_data), .fwd_hit(fwd_hit), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] dst; int rdy; int age; } wr_t;
    typedef struct { logic [NSRC*DW-1:0] data; logic [NSRC-1:0] hit; logic stall; } exp_t;

    wr_t  inflight[$];
    exp_t expq[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_cycle = 0;

    // Expected outputs for the current inputs. For each operand the model
    // looks for the youngest in-flight writer of the same register.
    function automatic exp_t model_resolve();
        exp_t e;
        e.data = src_rf;
        e.hit = '0;
        e.stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            logic [AW-1:0] a;
            int best;
            a = src_addr[i*AW +: AW];
            best = -1;
            if (a != 0) begin
                for (int j = 0; j < inflight.size(); j++)
                    if (inflight[j].dst == a && (best < 0 || inflight[j].age < inflight[best].age))
                        best = j;
            end
            if (best >= 0) begin
                int age;
                age = inflight[best].age;
                if (age >= inflight[best].rdy) begin
                    e.data[i*DW +: DW] = stage_data[age*DW +: DW];
                    e.hit[i] = 1'b1;
                end else if (src_used[i]) begin
                    e.stall = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Model update at the clock edge: writers age by one stage, writers that
    // leave the last stage retire, and an accepted issue enters at age 0.
    function automatic void model_clock();
        if (!reset_n || flush) begin
            inflight.delete();
        end else if (advance) begin
            for (int j = inflight.size() - 1; j >= 0; j--) begin
                inflight[j].age++;
                if (inflight[j].age >= NS) inflight.delete(j);
            end
            if (issue_valid && !cur_exp.stall && issue_dst != 0)
                inflight.push_back('{dst: issue_dst, rdy: int'(issue_rdy), age: 0});
        end
    endfunction

    task automatic clear_inputs();
        advance = 0; flush = 0; issue_valid = 0; issue_dst = 0; issue_rdy = 0;
        src_used = 0; src_addr = 0;
        for (int i = 0; i < NSRC; i++) src_rf[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        for (int k = 0; k < NS; k++) stage_data[k*DW +: DW] = 32'h5000_0000 + 32'(k);
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic used);
        src_addr[i*AW +: AW] = a;
        src_used[i] = used;
    endtask

    task automatic set_issue(input logic [AW-1:0] d, input int r);
        issue_valid = 1; issue_dst = d; issue_rdy = RW'(r);
    endtask

    // Record the expectation for the inputs driven now, then clock the model.
    task automatic step();
        if (!reset_n) inflight.delete();
        cur_exp = model_resolve();
        expq.push_back(cur_exp);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // Monitor
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                n_cycle++;
                n_checks += 3;
                if (src_data !== e.data) begin
                    n_fail++;
                    $display("FAIL src_data cyc %0d: got %h expected %h", n_cycle, src_data, e.data);
                end
                if (fwd_hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL fwd_hit cyc %0d: got %b expected %b", n_cycle, fwd_hit, e.hit);
                end
                if (stall !== e.stall) begin
                    n_fail++;
                    $display("FAIL stall cyc %0d: got %b expected %b", n_cycle, stall, e.stall);
                end
                $display("cyc %0d: data=%h hit=%b stall=%b", n_cycle, src_data, fwd_hit, stall);
            end
        end
    end

    // Stimulus
    initial begin
        reset_n = 0;
        clear_inputs();
        @(posedge clk);
        #1;
        // 1: reset state, A/B/C come straight from the register file
        set_src(0, 5'd1, 1); set_src(1, 5'd2, 1); set_src(2, 5'd3, 1);
        src_rf = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        set_issue(5'd1, 0); advance = 1;
        step(); step();
        reset_n = 1;
        clear_inputs();
        // 2: single-cycle producer, forwarded from stage 0
        set_issue(5'd8, 0); advance = 1; step();
        clear_inputs(); set_src(0, 5'd8, 1); stage_data[0 +: DW] = 32'hDEAD_BEEF; step();
        // 3: load-use: one stall cycle, then forward from stage 1
        clear_inputs(); flush = 1; step();
        clear_inputs(); set_issue(5'd9, 1); advance = 1; step();
        clear_inputs(); set_src(1, 5'd9, 1); set_issue(5'd10, 0); advance = 1; step();
        clear_inputs(); set_src(1, 5'd9, 1); advance = 1; step();
        // 4: two writers of r4, the younger one wins
        clear_inputs(); flush = 1; step();
        clear_inputs(); set_issue(5'd4, 0); advance = 1; step();
        clear_inputs(); set_issue(5'd5, 0); advance = 1; step();
        clear_inputs(); set_issue(5'd4, 0); advance = 1; step();
        clear_inputs(); set_src(0, 5'd4, 1); step();
        // 5: a write to r0 is never tracked
        clear_inputs(); flush = 1; step();
        clear_inputs(); set_issue(5'd0, 0); advance = 1; step();
        clear_inputs(); set_src(0, 5'd0, 1); step();
        // 6: a pending stall is killed by flush; a held tracker keeps stalling
        clear_inputs(); set_issue(5'd9, 2); advance = 1; step();
        clear_inputs(); set_src(0, 5'd9, 1); flush = 1; advance = 1; step();
        clear_inputs(); set_src(0, 5'd9, 1); step();
        clear_inputs(); set_issue(5'd7, NS); advance = 1; step();
        for (int c = 0; c < 3; c++) begin
            clear_inputs(); set_src(0, 5'd7, 1); step();
        end
        for (int c = 0; c < 4; c++) begin
            clear_inputs(); set_src(0, 5'd7, 1); advance = 1; step();
        end
        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            clear_inputs();
            reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            advance = ($urandom_range(0, 99) < 75);
            flush = ($urandom_range(0, 99) < 5);
            issue_valid = $urandom_range(0, 1);
            issue_dst = AW'($urandom_range(0, 7));
            issue_rdy = RW'($urandom_range(0, NS));
            src_used = NSRC'($urandom);
            for (int i = 0; i < NSRC; i++) begin
                src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                src_rf[i*DW +: DW] = $urandom;
            end
            for (int k = 0; k < NS; k++) stage_data[k*DW +: DW] = $urandom;
            step();
        end
        reset_n = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
